base_dbg_serial_arb: RTL

- Round-robin scheduler that shares one serial diagnostic output pin among n requesters.
- Each accepted request is a w-bit word. It is sent as a framed serial packet: start bit, requester id, data, even parity.
- Sits ahead of the chip-level diagnostic output latches, which take `sout` / `sout_v` as their `din`.

---
 rtl/base_dbg_serial_arb.sv | 103 ++++++++++
 1 files changed

// File: rtl/base_dbg_serial_arb.sv
// base_dbg_serial_arb: round-robin arbiter serialising requester words as framed packets
// Frame on sout: start bit, requester id MSB first, data slice index 0 first, even parity.
module base_dbg_serial_arb #(
    parameter int n = 4,
    parameter int w = 8,
    parameter int idw = (n == 1) ? 1 : $clog2(n)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [0:n-1]   req_v,
    input  logic [0:n*w-1] req_d,
    output logic [0:n-1]   req_r,
    output logic           sout,
    output logic           sout_v,
    output logic           busy
);
    localparam int mx = (idw > w) ? idw : w;
    localparam int cw = $clog2(mx + 1);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, ID = 3'd2, DATA = 3'd3, PAR = 3'd4;

    logic [2:0]     state;
    logic [idw-1:0] ptr, sid, gi;
    logic [0:w-1]   sdat, word;
    logic [cw-1:0]  cnt;
    logic           par, found;

    always_comb begin
        found = 1'b0;
        gi = '0;
        for (int k = 0; k < n; k++) begin
            if (!found && req_v[(int'(ptr) + k) % n]) begin
                found = 1'b1;
                gi = idw'((int'(ptr) + k) % n);
            end
        end
        word = req_d[int'(gi)*w +: w];
        for (int i = 0; i < n; i++)
            req_r[i] = (state == IDLE) && !reset && found && (gi == idw'(i));
    end

    assign busy = state != IDLE;

    // sout always presents the bit belonging to the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            sid    <= '0;
            sdat   <= '0;
            par    <= 1'b0;
            cnt    <= '0;
            sout   <= 1'b0;
            sout_v <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sout   <= found;
                    sout_v <= found;
                    if (found) begin
                        state <= START;
                        sid   <= gi;
                        sdat  <= word;
                        par   <= ^{gi, word};
                        ptr   <= (gi == idw'(n - 1)) ? '0 : gi + 1'b1;
                    end
                end
                START: begin
                    sout  <= sid[idw-1];
                    sid   <= sid << 1;
                    cnt   <= cw'(1);
                    state <= ID;
                end
                ID: begin
                    if (cnt == cw'(idw)) begin
                        sout  <= sdat[0];
                        sdat  <= sdat << 1;
                        cnt   <= cw'(1);
                        state <= DATA;
                    end else begin
                        sout <= sid[idw-1];
                        sid  <= sid << 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == cw'(w)) begin
                        sout  <= par;
                        state <= PAR;
                    end else begin
                        sout <= sdat[0];
                        sdat <= sdat << 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: begin
                    sout   <= 1'b0;
                    sout_v <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
